// File: rtl/ball_link_pkg.sv
// Shared constants, state type and frame byte mux for the ball hand-over link.
package ball_link_pkg;

    localparam logic [7:0] REG_Y_HI   = 8'd0;
    localparam logic [7:0] REG_Y_LO   = 8'd1;
    localparam logic [7:0] REG_SPEED  = 8'd2;
    localparam logic [7:0] REG_TRIG   = 8'd3;
    localparam logic [7:0] TRIG_VALUE = 8'h01;
    localparam int         FRAME_BYTES = 6;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        ACK,
        STOP
    } tx_state_t;

    // Byte idx of the burst write: address+W, register pointer, then the
    // register contents in the order the slave auto-increments through them.
    function automatic logic [7:0] frame_byte(input logic [2:0] idx,
                                              input logic [6:0] addr,
                                              input logic [9:0] y,
                                              input logic [7:0] vy);
        logic [7:0] b;
        case (idx)
            3'd0:    b = {addr, 1'b0};
            3'd1:    b = REG_Y_HI;
            3'd2:    b = {6'b0, y[9:8]};
            3'd3:    b = y[7:0];
            3'd4:    b = vy;
            default: b = TRIG_VALUE;
        endcase
        return b;
    endfunction

endpackage

// File: rtl/i2c_phase_timer.sv
// Quarter-period timer for the I2C master: ticks on the last cycle of every
// quarter and keeps the index of the current quarter within a bus phase.
module i2c_phase_timer import ball_link_pkg::*; #(
    parameter int unsigned CLK_DIV_QTR = 62
) (
    input  logic       clk_25MHZ,
    input  logic       reset,
    input  logic       clear,
    input  logic       restart,
    output logic       tick,
    output logic [1:0] phase
);

    localparam logic [7:0] RELOAD = 8'(CLK_DIV_QTR - 1);

    logic [7:0] qtr_cnt;

    assign tick = ~clear & (qtr_cnt == 8'd0);

    // Down-count each quarter; restart folds the phase back to 0 at the end of a bus phase.
    always_ff @(posedge clk_25MHZ or posedge reset) begin
        if (reset) begin
            qtr_cnt <= 8'd0;
            phase   <= 2'd0;
        end else if (clear) begin
            qtr_cnt <= RELOAD;
            phase   <= 2'd0;
        end else if (qtr_cnt == 8'd0) begin
            qtr_cnt <= RELOAD;
            phase   <= restart ? 2'd0 : phase + 2'd1;
        end else begin
            qtr_cnt <= qtr_cnt - 8'd1;
        end
    end

endmodule

// File: rtl/ball_link_tx.sv
// Single-master I2C transmitter that writes the ball's Y position and
// velocity into the opposite board's registers on each send trigger edge.
module ball_link_tx import ball_link_pkg::*; #(
    parameter logic [6:0]  SLAVE_ADDR  = 7'h50,
    parameter int unsigned CLK_DIV_QTR = 62
) (
    input  logic       clk_25MHZ,
    input  logic       reset,
    input  logic       send_trigger,
    input  logic [9:0] ball_y,
    input  logic [7:0] ball_vy,
    input  logic       sda_i,
    output logic       scl,
    output logic       sda_oe,
    output logic       busy,
    output logic       done,
    output logic       ack_error
);

    tx_state_t  state;
    logic       send_trigger_d;
    logic       trigger_edge;
    logic [9:0] y_q;
    logic [7:0] vy_q;
    logic [2:0] byte_cnt;
    logic [3:0] bit_cnt;
    logic [7:0] shift_q;
    logic       nack_q;
    logic       tick;
    logic [1:0] phase;
    logic       last_qtr;
    logic [2:0] next_idx;
    logic [7:0] next_byte;

    assign trigger_edge = send_trigger & ~send_trigger_d;
    assign next_idx     = (state == START) ? 3'd0 : byte_cnt + 3'd1;
    assign next_byte    = frame_byte(next_idx, SLAVE_ADDR, y_q, vy_q);

    i2c_phase_timer #(
        .CLK_DIV_QTR(CLK_DIV_QTR)
    ) u_timer (
        .clk_25MHZ(clk_25MHZ),
        .reset    (reset),
        .clear    (state == IDLE),
        .restart  (last_qtr),
        .tick     (tick),
        .phase    (phase)
    );

    // Flag the final quarter of each bus phase so the timer restarts at q0.
    always_comb begin
        last_qtr = 1'b0;
        case (state)
            START:     last_qtr = (phase == 2'd1);
            DATA, ACK: last_qtr = (phase == 2'd3);
            STOP:      last_qtr = (phase == 2'd2);
            default:   last_qtr = 1'b0;
        endcase
    end

    // Frame sequencer: outputs are registered and updated at quarter ticks,
    // so each new level appears on the first cycle of the following quarter.
    always_ff @(posedge clk_25MHZ or posedge reset) begin
        if (reset) begin
            state          <= IDLE;
            send_trigger_d <= 1'b0;
            y_q            <= 10'd0;
            vy_q           <= 8'd0;
            byte_cnt       <= 3'd0;
            bit_cnt        <= 4'd0;
            shift_q        <= 8'd0;
            nack_q         <= 1'b0;
            scl            <= 1'b1;
            sda_oe         <= 1'b0;
            busy           <= 1'b0;
            done           <= 1'b0;
            ack_error      <= 1'b0;
        end else begin
            send_trigger_d <= send_trigger;
            done           <= 1'b0;
            ack_error      <= 1'b0;
            case (state)
                IDLE: begin
                    if (trigger_edge) begin
                        state  <= START;
                        busy   <= 1'b1;
                        y_q    <= ball_y;
                        vy_q   <= ball_vy;
                        nack_q <= 1'b0;
                        scl    <= 1'b1;
                        sda_oe <= 1'b0;
                    end
                end
                START: begin
                    byte_cnt <= 3'd0;
                    bit_cnt  <= 4'd0;
                    if (tick) begin
                        if (phase == 2'd0) begin
                            sda_oe <= 1'b1;
                        end else begin
                            state   <= DATA;
                            scl     <= 1'b0;
                            sda_oe  <= ~next_byte[7];
                            shift_q <= {next_byte[6:0], 1'b0};
                        end
                    end
                end
                DATA: begin
                    if (tick) begin
                        if (phase == 2'd1) begin
                            scl <= 1'b1;
                        end else if (phase == 2'd3) begin
                            scl <= 1'b0;
                            if (bit_cnt == 4'd7) begin
                                state   <= ACK;
                                bit_cnt <= 4'd8;
                                sda_oe  <= 1'b0;
                            end else begin
                                bit_cnt <= bit_cnt + 4'd1;
                                sda_oe  <= ~shift_q[7];
                                shift_q <= {shift_q[6:0], 1'b0};
                            end
                        end
                    end
                end
                ACK: begin
                    if (tick) begin
                        if (phase == 2'd1) begin
                            scl <= 1'b1;
                        end else if (phase == 2'd2) begin
                            nack_q <= sda_i;
                        end else if (phase == 2'd3) begin
                            scl <= 1'b0;
                            if (nack_q || byte_cnt == 3'(FRAME_BYTES - 1)) begin
                                state  <= STOP;
                                sda_oe <= 1'b1;
                            end else begin
                                state    <= DATA;
                                byte_cnt <= byte_cnt + 3'd1;
                                bit_cnt  <= 4'd0;
                                sda_oe   <= ~next_byte[7];
                                shift_q  <= {next_byte[6:0], 1'b0};
                            end
                        end
                    end
                end
                STOP: begin
                    if (tick) begin
                        if (phase == 2'd0) begin
                            scl <= 1'b1;
                        end else if (phase == 2'd1) begin
                            sda_oe <= 1'b0;
                        end else begin
                            state     <= IDLE;
                            busy      <= 1'b0;
                            done      <= 1'b1;
                            ack_error <= nack_q;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ball_link_tx.sv
// Self-checking bench for ball_link_tx: an I2C bus monitor with a slave
// responder decodes every frame and compares it with a byte-list model.
module tb_ball_link_tx;

    localparam int         Q    = 62;
    localparam logic [6:0] ADDR = 7'h50;

    logic       clk_25MHZ    = 1'b0;
    logic       reset        = 1'b0;
    logic       send_trigger = 1'b0;
    logic [9:0] ball_y       = 10'd0;
    logic [7:0] ball_vy      = 8'd0;
    logic       scl, sda_oe, busy, done, ack_error;
    logic       slave_pull   = 1'b0;
    wire        sda_line     = ~sda_oe & ~slave_pull;

    int compared   = 0;
    int mismatched = 0;
    int cyc        = 0;
    int starts     = 0;
    int frames     = 0;
    int busy_rises = 0;
    int nack_byte  = -1;
    int t_edge     = 0;
    logic [7:0] cur_bytes[$];
    logic [7:0] last_frame[$];

    ball_link_tx #(
        .SLAVE_ADDR (ADDR),
        .CLK_DIV_QTR(Q)
    ) dut (
        .clk_25MHZ   (clk_25MHZ),
        .reset       (reset),
        .send_trigger(send_trigger),
        .ball_y      (ball_y),
        .ball_vy     (ball_vy),
        .sda_i       (sda_line),
        .scl         (scl),
        .sda_oe      (sda_oe),
        .busy        (busy),
        .done        (done),
        .ack_error   (ack_error)
    );

    initial forever #20 clk_25MHZ = ~clk_25MHZ;

    initial forever begin
        @(posedge clk_25MHZ);
        cyc++;
    end

    // Bus monitor and slave: decodes START/STOP/bits and ACKs every byte except nack_byte.
    initial begin
        logic       scl_p, sda_p, busy_p;
        logic [7:0] sh;
        int         bits;
        scl_p = 1'b1; sda_p = 1'b1; busy_p = 1'b0; sh = 8'd0; bits = 0;
        forever begin
            @(negedge clk_25MHZ);
            if (busy === 1'b1 && busy_p === 1'b0) busy_rises++;
            if (reset) begin
                slave_pull = 1'b0;
                bits = 0;
            end else if (scl_p && scl && sda_p && !sda_line) begin
                cur_bytes.delete();
                bits = 0;
                starts++;
            end else if (scl_p && scl && !sda_p && sda_line) begin
                last_frame = cur_bytes;
                frames++;
            end else if (!scl_p && scl) begin
                if (bits < 8) sh = {sh[6:0], sda_line};
                bits++;
                if (bits == 9) begin
                    cur_bytes.push_back(sh);
                    bits = 0;
                end
            end else if (scl_p && !scl) begin
                slave_pull = (bits == 8) && (cur_bytes.size() != nack_byte);
            end
            scl_p  = scl;
            sda_p  = sda_line;
            busy_p = busy;
        end
    end

    // Expected content of frame byte idx, from the register map.
    function automatic logic [7:0] model_byte(input int idx, input logic [9:0] y, input logic [7:0] vy);
        case (idx)
            0:       return 8'(ADDR * 2);
            1:       return 8'h00;
            2:       return 8'(y / 256);
            3:       return 8'(y % 256);
            4:       return vy;
            default: return 8'h01;
        endcase
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Present new ball values with a trigger edge in the current cycle.
    task automatic applyStimulus(input string tag, input logic [9:0] y, input logic [7:0] vy, input bit hold);
        @(negedge clk_25MHZ);
        ball_y       = y;
        ball_vy      = vy;
        send_trigger = 1'b1;
        t_edge       = cyc;
        @(negedge clk_25MHZ);
        checkOutput({tag, "_busy_rise"}, 32'(busy), 32'd1);
        if (!hold) send_trigger = 1'b0;
    endtask

    task automatic expectFrame(input string tag, input logic [9:0] y, input logic [7:0] vy,
                               input int nack_k, input bit retrig,
                               input logic [9:0] ny, input logic [7:0] nvy);
        int nb, len, t_done, f0;
        bit ok;
        nb = (nack_k < 0) ? 6 : nack_k + 1;
        len = Q * (2 + 36 * nb + 3);
        f0 = frames;
        ok = 1'b0;
        t_done = 0;
        for (int i = 0; i < 15000 && !ok; i++) begin
            @(negedge clk_25MHZ);
            if (done === 1'b1) begin
                ok = 1'b1;
                t_done = cyc;
            end
        end
        checkOutput({tag, "_done_seen"}, 32'(ok), 32'd1);
        checkOutput({tag, "_len"}, 32'(t_done - t_edge - 1), 32'(len));
        checkOutput({tag, "_busy_at_done"}, 32'(busy), 32'd0);
        checkOutput({tag, "_ack_error"}, 32'(ack_error), 32'(nack_k >= 0));
        if (retrig) begin
            ball_y       = ny;
            ball_vy      = nvy;
            send_trigger = 1'b1;
            t_edge       = cyc;
        end
        @(negedge clk_25MHZ);
        checkOutput({tag, "_done_pulse"}, 32'(done), 32'd0);
        checkOutput({tag, "_ackerr_pulse"}, 32'(ack_error), 32'd0);
        if (retrig) begin
            checkOutput({tag, "_rebusy"}, 32'(busy), 32'd1);
            send_trigger = 1'b0;
        end
        checkOutput({tag, "_frames"}, 32'(frames - f0), 32'd1);
        checkOutput({tag, "_nbytes"}, 32'(last_frame.size()), 32'(nb));
        for (int i = 0; i < nb; i++) begin
            checkOutput($sformatf("%s_byte%0d", tag, i),
                        (i < last_frame.size()) ? 32'(last_frame[i]) : 32'hDEAD,
                        32'(model_byte(i, y, vy)));
        end
    endtask

    initial begin
        int         bad, rises0, k;
        logic [9:0] y, y2;
        logic [7:0] vy, vy2;

        // Reset state and a quiet bus
        #1 reset = 1'b1;
        repeat (3) @(negedge clk_25MHZ);
        checkOutput("rst_scl", 32'(scl), 32'd1);
        checkOutput("rst_sda_oe", 32'(sda_oe), 32'd0);
        checkOutput("rst_busy", 32'(busy), 32'd0);
        checkOutput("rst_done", 32'(done), 32'd0);
        checkOutput("rst_ack_error", 32'(ack_error), 32'd0);
        reset = 1'b0;
        bad = 0;
        repeat (1000) begin
            @(negedge clk_25MHZ);
            if (scl !== 1'b1 || sda_oe !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || ack_error !== 1'b0) bad++;
        end
        checkOutput("idle_quiet", 32'(bad), 32'd0);
        checkOutput("idle_starts", 32'(starts), 32'd0);

        // Directed frame with all bytes ACKed
        $display("[TB] full frame 2A5/FD");
        applyStimulus("f1", 10'h2A5, 8'hFD, 1'b0);
        expectFrame("f1", 10'h2A5, 8'hFD, -1, 1'b0, 10'd0, 8'd0);

        // Address NACK, then a NACK on a random later byte
        $display("[TB] NACK frames");
        nack_byte = 0;
        y = 10'($urandom_range(0, 1023)); vy = 8'($urandom);
        applyStimulus("nack0", y, vy, 1'b0);
        expectFrame("nack0", y, vy, 0, 1'b0, 10'd0, 8'd0);
        k = $urandom_range(1, 2);
        nack_byte = k;
        y = 10'($urandom_range(0, 1023)); vy = 8'($urandom);
        applyStimulus("nackk", y, vy, 1'b0);
        expectFrame("nackk", y, vy, k, 1'b0, 10'd0, 8'd0);
        nack_byte = -1;

        // Trigger held high with inputs changing mid-frame
        $display("[TB] held trigger");
        rises0 = busy_rises;
        y = 10'($urandom_range(0, 1023)); vy = 8'($urandom);
        applyStimulus("held", y, vy, 1'b1);
        repeat (5000) @(negedge clk_25MHZ);
        ball_y  = y ^ 10'h3FF;
        ball_vy = ~vy;
        expectFrame("held", y, vy, -1, 1'b0, 10'd0, 8'd0);
        repeat (20000 - (cyc - t_edge)) @(negedge clk_25MHZ);
        checkOutput("held_one_frame", 32'(busy_rises - rises0), 32'd1);
        checkOutput("held_idle", 32'(busy), 32'd0);
        send_trigger = 1'b0;

        // Reset in byte 3 bit 4 (scl low quarter), then back-to-back frames
        $display("[TB] reset mid-frame");
        y = 10'($urandom_range(0, 1023)); vy = 8'($urandom);
        applyStimulus("rstmid", y, vy, 1'b0);
        repeat (127 * Q) @(negedge clk_25MHZ);
        checkOutput("rstmid_busy_before", 32'(busy), 32'd1);
        checkOutput("rstmid_scl_before", 32'(scl), 32'd0);
        reset = 1'b1;
        #1;
        checkOutput("rstmid_scl", 32'(scl), 32'd1);
        checkOutput("rstmid_sda_oe", 32'(sda_oe), 32'd0);
        checkOutput("rstmid_busy", 32'(busy), 32'd0);
        repeat (3) @(negedge clk_25MHZ);
        reset = 1'b0;
        repeat (5) @(negedge clk_25MHZ);

        $display("[TB] back-to-back frames");
        y  = 10'($urandom_range(0, 1023)); vy  = 8'($urandom);
        y2 = 10'($urandom_range(0, 1023)); vy2 = 8'($urandom);
        applyStimulus("b2b_a", y, vy, 1'b0);
        expectFrame("b2b_a", y, vy, -1, 1'b1, y2, vy2);
        expectFrame("b2b_b", y2, vy2, -1, 1'b0, 10'd0, 8'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
